filter_ctrl: RTL and testbench
==============================

# filter_ctrl

Sequencer and configuration front-end for the SID filter path. It decodes SID filter register writes into shadow registers and generates the per-sample `sample_valid` strobe. At sample boundaries it transfers shadow values to the filter's live `fc/res/filt/mode/vol` inputs. Cutoff is slew-limited, and mode/routing changes are wrapped in a volume fade-out/swap/fade-in sequence so the filter never switches topology at audible level.

## Interface

- `CLK_DIV`, default 24: clocks per sample; `sample_valid` period; legal range ≥ 2.
- `SLEW_STEP`, default 16: maximum `fc` change per sample; 0 means `fc` loads the target directly.
- `clk` in, 1: system clock; all logic on the rising edge.
- `rst` in, 1: asynchronous, active-high reset.
- `wr_en` in, 1: register write strobe, one cycle per write.
- `wr_addr` in, 5: SID register address.
- `wr_data` in, 8: write data.
- `sample_valid` out, 1: one-cycle sample strobe to the filter and voices.
- `fc` out, 11: live cutoff.
- `res` out, 4: live resonance.
- `filt` out, 4: live routing.
- `mode` out, 4: live mode.
- `vol` out, 4: live volume.
- `busy` out, 1: high whenever the FSM is not in RUN.

## Operation

- **Register decode.** Decoding happens on `wr_en`; all other addresses are ignored.
  - 0x15: `sh_fc[2:0] = wr_data[2:0]`.
  - 0x16: `sh_fc[10:3] = wr_data`.
  - 0x17: `sh_res = wr_data[7:4]`, `sh_filt = wr_data[3:0]`.
  - 0x18: `sh_mode = wr_data[7:4]`, `sh_vol = wr_data[3:0]`.
  - Shadow registers update on the write edge.
- **Sample counter.** Counts 0..CLK_DIV-1 and wraps. `sample_valid`=1 while count==CLK_DIV-1.
- **Boundary edge.** The clock edge that ends a `sample_valid` cycle is the boundary. All live-register updates happen only at boundaries.
- **Shadow value used at a boundary.** Each boundary uses the shadow values as they stood before that edge. A write on the boundary edge takes effect at the next boundary.
- **`fc` slew, every boundary, any state.**
  - d = sh_fc − fc, computed 12-bit signed.
  - If |d| ≤ SLEW_STEP, or SLEW_STEP==0: `fc` ← `sh_fc`.
  - Otherwise `fc` ← fc ± SLEW_STEP, toward the target.
  - No overshoot and no wrap.
- **`res`.** `res` ← `sh_res` at every boundary, in any state.
- **FSM.** Evaluated only at boundaries.
  - RUN:
    - If `{sh_mode, sh_filt}` ≠ `{mode, filt}`: go to FADE_OUT; `vol` unchanged.
    - Otherwise `vol` steps ±1 toward `sh_vol`, holding when equal.
  - FADE_OUT:
    - If `vol`==0: go to SWAP.
    - Otherwise `vol` ← vol−1.
    - Continues to 0 even if the shadow reverts to match the live values.
  - SWAP: `mode` ← `sh_mode`, `filt` ← `sh_filt`; go to FADE_IN.
  - FADE_IN:
    - If `vol`==`sh_vol`: go to RUN.
    - Otherwise `vol` steps ±1 toward the current `sh_vol`, which is tracked live.
    - `mode`/`filt` changes arriving during FADE_IN are handled once back in RUN.
- **`busy`.** `busy` = (state ≠ RUN), registered together with the state.

## Timing

- **Reset values.** All outputs, shadow registers and the counter are 0; state is RUN. `busy`=0 and `sample_valid`=0.
- **Reset mid-fade.** The fade sequence is abandoned immediately.
- **First strobe.** The first `sample_valid` occurs in the CLK_DIV-th cycle after `rst` deasserts, i.e. at count CLK_DIV-1.
- **Strobe shape.** `sample_valid` is exactly one cycle wide, with period CLK_DIV. It is never suppressed by `busy` or by writes.
- **Live-output stability.** Live outputs change only on the boundary edge. They are therefore stable for CLK_DIV cycles, including the whole cycle in which `sample_valid` is high.
- **Write latency.** A write lands in shadow 1 cycle after the write. It reaches the outputs at the first boundary after that, and for `fc` only after the slew completes.
- **Full fade sequence.** A mode change at `vol`=V (V>0, `sh_vol`=V) takes 2V+4 boundaries from the RUN detection to the return to RUN:
  - 1 boundary for detection;
  - V boundaries of decrement;
  - 1 boundary for the 0→SWAP transition;
  - 1 boundary for SWAP;
  - V boundaries of increment;
  - 1 boundary for the exit to RUN.

## Test plan

- **Reset and strobe.** CLK_DIV=4; reset, then release → `sample_valid` high in cycles 3, 7, 11…; all outputs 0; `busy`=0. Assert `rst` mid-count → counter and outputs are 0 asynchronously.
- **Cutoff slew.** SLEW_STEP=16; write 0x16=0x10 (`sh_fc`=128) → `fc` goes 16, 32 … 128 over 8 boundaries, then holds. Write 0x16=0x0F (`sh_fc`=120) → `fc`=120 at the next boundary (|d|=8).
- **Boundary-edge write.** Write 0x17=0xA3 on the boundary edge → `res`/`filt` unchanged at that boundary; `res`=0xA (`filt`=3 via the FSM) at the next boundary.
- **Fade sequence.** With `vol`=15 and `mode`=1 in RUN, write 0x18=0x4F → `busy` rises at boundary 1; `vol` reaches 0 at boundary 16; SWAP at 17; `mode`=4 after boundary 18; `vol`=15 at boundary 33; RUN with `busy`=0 after boundary 34.
- **Live volume in RUN.** Write 0x18 with the same mode and `vol` 0→5 → `vol` steps 1..5 over 5 boundaries; `busy` stays 0.
- **Retarget during FADE_IN.** During FADE_IN, write `sh_vol`=3 while `vol`=7 → `vol` steps down to 3, then RUN.

Source files
------------

// File: rtl/filter_ctrl.sv
// filter_ctrl: SID filter register decode, per-sample strobe generation and
// boundary-synchronous transfer of shadow settings to the live filter inputs.
// Cutoff is slew-limited; mode/routing changes are wrapped in a volume
// fade-out / swap / fade-in sequence so topology never switches at level.
module filter_ctrl #(
  parameter int CLK_DIV   = 24,
  parameter int SLEW_STEP = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [7:0]  wr_data,
  output logic        sample_valid,
  output logic [10:0] fc,
  output logic [3:0]  res,
  output logic [3:0]  filt,
  output logic [3:0]  mode,
  output logic [3:0]  vol,
  output logic        busy
);

  localparam int              CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [10:0]      STEP_FC  = 11'(SLEW_STEP);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FADE_OUT = 2'd1,
    SWAP     = 2'd2,
    FADE_IN  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;

  logic [10:0] sh_fc;
  logic [3:0]  sh_res;
  logic [3:0]  sh_filt;
  logic [3:0]  sh_mode;
  logic [3:0]  sh_vol;

  logic [3:0]  vol_nxt;
  logic [3:0]  mode_nxt;
  logic [3:0]  filt_nxt;

  // Move cutoff toward its target by at most SLEW_STEP; lands exactly on the
  // target once within one step, so it never overshoots or wraps.
  function automatic logic [10:0] slew_fc(input logic [10:0] cur,
                                          input logic [10:0] tgt);
    logic signed [11:0] d;
    logic [11:0]        mag;
    d   = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    mag = d[11] ? $unsigned(-d) : $unsigned(d);
    if ((SLEW_STEP == 0) || (int'(mag) <= SLEW_STEP))
      return tgt;
    else if (d[11])
      return cur - STEP_FC;
    else
      return cur + STEP_FC;
  endfunction

  // Single-unit volume step toward a target, holding once it is reached.
  function automatic logic [3:0] step_vol(input logic [3:0] cur,
                                          input logic [3:0] tgt);
    if (cur < tgt)
      return cur + 4'd1;
    else if (cur > tgt)
      return cur - 4'd1;
    else
      return cur;
  endfunction

  // The strobe is a decode of the counter, so it is low as soon as reset hits.
  assign sample_valid = (cnt == CNT_LAST);

  // Free-running sample counter, wraps at CLK_DIV-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (sample_valid)
      cnt <= '0;
    else
      cnt <= cnt + CNT_W'(1);
  end

  // Register-write decode into the shadow copies.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_fc   <= '0;
      sh_res  <= '0;
      sh_filt <= '0;
      sh_mode <= '0;
      sh_vol  <= '0;
    end else if (wr_en) begin
      case (wr_addr)
        5'h15: sh_fc[2:0]  <= wr_data[2:0];
        5'h16: sh_fc[10:3] <= wr_data;
        5'h17: begin
          sh_res  <= wr_data[7:4];
          sh_filt <= wr_data[3:0];
        end
        5'h18: begin
          sh_mode <= wr_data[7:4];
          sh_vol  <= wr_data[3:0];
        end
        default: ;
      endcase
    end
  end

  // Fade sequencer: next state and next volume/mode/routing for a boundary.
  always_comb begin
    state_nxt = state;
    vol_nxt   = vol;
    mode_nxt  = mode;
    filt_nxt  = filt;
    case (state)
      RUN: begin
        if ({sh_mode, sh_filt} != {mode, filt})
          state_nxt = FADE_OUT;
        else
          vol_nxt = step_vol(vol, sh_vol);
      end
      FADE_OUT: begin
        // Runs to silence even if the shadow reverts meanwhile.
        if (vol == 4'd0)
          state_nxt = SWAP;
        else
          vol_nxt = vol - 4'd1;
      end
      SWAP: begin
        mode_nxt  = sh_mode;
        filt_nxt  = sh_filt;
        state_nxt = FADE_IN;
      end
      FADE_IN: begin
        // Target volume is tracked live; new mode/routing waits for RUN.
        if (vol == sh_vol)
          state_nxt = RUN;
        else
          vol_nxt = step_vol(vol, sh_vol);
      end
      default: state_nxt = RUN;
    endcase
  end

  // Live outputs and FSM state advance only on the boundary edge, using the
  // shadow values as they stood before that edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      busy  <= 1'b0;
      fc    <= '0;
      res   <= '0;
      filt  <= '0;
      mode  <= '0;
      vol   <= '0;
    end else if (sample_valid) begin
      state <= state_nxt;
      busy  <= (state_nxt != RUN);
      fc    <= slew_fc(fc, sh_fc);
      res   <= sh_res;
      filt  <= filt_nxt;
      mode  <= mode_nxt;
      vol   <= vol_nxt;
    end
  end

endmodule

// File: tb/tb_filter_ctrl.sv
// Bench for filter_ctrl: a boundary-level reference model predicts the live
// outputs into a queue that is drained against the DUT after each boundary,
// alongside directed checks of the documented sequences.
module tb_filter_ctrl;

  localparam int CLK_DIV = 4;
  localparam int SLEW    = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        sample_valid;
  logic [10:0] fc;
  logic [3:0]  res;
  logic [3:0]  filt;
  logic [3:0]  mode;
  logic [3:0]  vol;
  logic        busy;

  int total = 0;
  int bad   = 0;

  filter_ctrl #(.CLK_DIV(CLK_DIV), .SLEW_STEP(SLEW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sample_valid(sample_valid), .fc(fc), .res(res), .filt(filt),
    .mode(mode), .vol(vol), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [10:0] m_sh_fc, m_fc;
  logic [3:0]  m_sh_res, m_sh_filt, m_sh_mode, m_sh_vol;
  logic [3:0]  m_res, m_filt, m_mode, m_vol;
  int          ms;
  int          tb_cnt;
  int          dfc;
  logic [27:0] exp_q[$];
  logic [27:0] e_vec;

  // Monitor/scoreboard on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        m_sh_fc = '0; m_fc = '0;
        m_sh_res = '0; m_sh_filt = '0; m_sh_mode = '0; m_sh_vol = '0;
        m_res = '0; m_filt = '0; m_mode = '0; m_vol = '0;
        ms = 0; tb_cnt = 0;
        exp_q.delete();
      end else begin
        if (exp_q.size() > 0) begin
          e_vec = exp_q.pop_front();
          check("live", {fc, res, filt, mode, vol, busy}, {4'h0, e_vec});
        end
        check("sv", sample_valid, tb_cnt == CLK_DIV - 1);
        if (tb_cnt == CLK_DIV - 1) begin
          dfc = int'(m_sh_fc) - int'(m_fc);
          if (SLEW == 0 || (dfc <= SLEW && dfc >= -SLEW)) m_fc = m_sh_fc;
          else if (dfc > 0) m_fc = m_fc + 11'(SLEW);
          else m_fc = m_fc - 11'(SLEW);
          m_res = m_sh_res;
          case (ms)
            0: if ({m_sh_mode, m_sh_filt} != {m_mode, m_filt}) ms = 1;
               else if (m_vol < m_sh_vol) m_vol++;
               else if (m_vol > m_sh_vol) m_vol--;
            1: if (m_vol == 0) ms = 2; else m_vol--;
            2: begin m_mode = m_sh_mode; m_filt = m_sh_filt; ms = 3; end
            default:
              if (m_vol == m_sh_vol) ms = 0;
              else if (m_vol < m_sh_vol) m_vol++;
              else m_vol--;
          endcase
          exp_q.push_back({m_fc, m_res, m_filt, m_mode, m_vol, ms != 0});
        end
        if (wr_en) begin
          case (wr_addr)
            5'h15: m_sh_fc[2:0] = wr_data[2:0];
            5'h16: m_sh_fc[10:3] = wr_data;
            5'h17: {m_sh_res, m_sh_filt} = wr_data;
            5'h18: {m_sh_mode, m_sh_vol} = wr_data;
            default: ;
          endcase
        end
        tb_cnt = (tb_cnt + 1) % CLK_DIV;
      end
    end
  end

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Advance until sample_valid is high (bounded)
  task automatic to_sv();
    for (int i = 0; i < 2 * CLK_DIV; i++) begin
      if (sample_valid) return;
      @(posedge clk); #1;
    end
    check("sv_timeout", 32'd0, 32'd1);
  endtask

  // Return just after the next boundary edge
  task automatic boundary();
    to_sv();
    @(posedge clk); #1;
  endtask

  task automatic settle(input logic [3:0] v);
    for (int i = 0; i < 60; i++) begin
      boundary();
      if (!busy && vol == v) return;
    end
    check("settle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic found;
    repeat (3) @(posedge clk); #1;
    check("rst_out", {fc, res, filt, mode, vol}, 32'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_sv", sample_valid, 1'b0);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      check("strobe", sample_valid, (c % CLK_DIV) == CLK_DIV - 1);
      @(posedge clk); #1;
    end

    // Cutoff slew up, small step, then down
    wr(5'h16, 8'h10);
    for (int k = 1; k <= 8; k++) begin
      boundary();
      check("fc_up", fc, 11'(16 * k));
    end
    boundary();
    check("fc_hold", fc, 11'd128);
    wr(5'h16, 8'h0F);
    boundary();
    check("fc_small", fc, 11'd120);
    wr(5'h15, 8'h05);
    wr(5'h16, 8'h02);
    repeat (6) boundary();
    check("fc_down_mid", fc, 11'd24);
    boundary();
    check("fc_down", fc, 11'd21);

    // Write landing on the boundary edge
    to_sv();
    wr(5'h17, 8'hA3);
    check("bedge_res", res, 4'h0);
    check("bedge_filt", filt, 4'h0);
    boundary();
    check("bnext_res", res, 4'hA);
    check("bnext_busy", busy, 1'b1);
    check("bnext_filt", filt, 4'h0);
    boundary();
    boundary();
    check("route_filt", filt, 4'h3);
    boundary();
    check("route_done", busy, 1'b0);

    // Establish vol=15, mode=1
    wr(5'h18, 8'h1F);
    settle(4'hF);
    check("setup_mode", mode, 4'h1);

    // Full fade sequence
    wr(5'h18, 8'h4F);
    for (int b = 1; b <= 34; b++) begin
      boundary();
      if (b == 1)  check("fade_b1", {busy, vol}, {1'b1, 4'hF});
      if (b == 16) check("fade_b16", {busy, vol}, {1'b1, 4'h0});
      if (b == 17) check("fade_b17", {busy, mode}, {1'b1, 4'h1});
      if (b == 18) check("fade_b18", mode, 4'h4);
      if (b == 33) check("fade_b33", {busy, vol}, {1'b1, 4'hF});
      if (b == 34) check("fade_b34", busy, 1'b0);
    end

    // Live volume in RUN
    wr(5'h18, 8'h40);
    settle(4'h0);
    wr(5'h18, 8'h45);
    for (int k = 1; k <= 5; k++) begin
      boundary();
      check("live_vol", {busy, vol}, {1'b0, 4'(k)});
    end

    // Retarget during FADE_IN
    wr(5'h18, 8'h2F);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      boundary();
      if (busy && vol == 4'd7 && mode == 4'd2) found = 1'b1;
    end
    check("retgt_reach", found, 1'b1);
    wr(5'h18, 8'h23);
    for (int k = 6; k >= 3; k--) begin
      boundary();
      check("retgt_vol", {busy, vol}, {1'b1, 4'(k)});
    end
    boundary();
    check("retgt_run", {busy, vol}, {1'b0, 4'h3});

    // Asynchronous reset in the middle of a fade
    wr(5'h18, 8'h5F);
    boundary();
    boundary();
    check("mid_busy", busy, 1'b1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("arst_out", {fc, res, filt, mode, vol}, 32'd0);
    check("arst_busy", busy, 1'b0);
    check("arst_sv", sample_valid, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    boundary();
    check("post_rst", {fc, res, filt, mode, vol, busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
